// File: rtl/bcd_timer_ctrl.sv
// Run/pause/clear sequencer for a cascaded BCD counter chain with prescaled
// count ticks, decade carry enables and a programmable BCD terminal value.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   A_count,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            state
);

    // state   | meaning
    // S_IDLE  | count zeroed, waiting for start
    // S_RUN   | prescaler advancing, count increments on each tick
    // S_PAUSE | count and prescaler frozen, start resumes mid-period
    // S_DONE  | terminal value reached, count holds limit
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam int             PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic                  running_q, running_d;

    logic                  tick;
    logic                  carry;
    logic                  limit_ok;
    logic                  term;
    logic [4*DIGITS-1:0]   count_inc;

    assign tick = (state_q == S_RUN) && (presc_q == P_LAST) && !stop && !clear;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        if (clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    count_d = count_inc;
                    // A stop landing on the last prescale cycle holds the
                    // prescaler there so the resume ticks on its first edge.
                    if (presc_q == P_LAST)
                        presc_d = tick ? '0 : presc_q;
                    else
                        presc_d = presc_q + 1'b1;
                    if (stop)
                        state_d = S_PAUSE;
                    else if (term)
                        state_d = S_DONE;
                end
                S_PAUSE: begin
                    if (start && !stop)
                        state_d = S_RUN;
                end
                S_DONE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                        count_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        done_d    = term;
        running_d = (state_d == S_RUN);
    end

    always_comb begin
        digit_en  = '0;
        count_inc = count_q;
        carry     = tick;
        for (int k = 0; k < DIGITS; k++) begin
            digit_en[k] = carry;
            if (carry)
                count_inc[4*k +: 4] = (count_q[4*k +: 4] == 4'd9) ? 4'd0 : count_q[4*k +: 4] + 4'd1;
            carry = carry && (count_q[4*k +: 4] == 4'd9);
        end
    end

    // A zero or non-BCD limit can never match, so the chain free-runs.
    always_comb begin
        limit_ok = (limit != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (limit[4*k +: 4] > 4'd9)
                limit_ok = 1'b0;
        end
    end

    assign term    = tick && limit_ok && (count_inc == limit);

    assign A_count = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: one 4-digit instance at PRESCALE=4 and
// one at PRESCALE=1 for the full-scale wrap.
module tb_bcd_timer_ctrl;

    logic        CLK;
    logic        reset;
    logic        start, stop, clear;
    logic [15:0] limit;
    logic [15:0] A_count;
    logic [3:0]  digit_en;
    logic        running, done;
    logic [1:0]  state;

    logic        start1, stop1, clear1;
    logic [15:0] limit1;
    logic [15:0] A_count1;
    logic [3:0]  digit_en1;
    logic        running1, done1;
    logic [1:0]  state1;

    int checks = 0;
    int errors = 0;
    int ndone;
    int bad;

    bcd_timer_ctrl #(.DIGITS(4), .PRESCALE(4)) u_dut (
        .CLK(CLK), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .A_count(A_count), .digit_en(digit_en),
        .running(running), .done(done), .state(state)
    );

    bcd_timer_ctrl #(.DIGITS(4), .PRESCALE(1)) u_dut1 (
        .CLK(CLK), .reset(reset), .start(start1), .stop(stop1), .clear(clear1),
        .limit(limit1), .A_count(A_count1), .digit_en(digit_en1),
        .running(running1), .done(done1), .state(state1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 0; stop = 0; clear = 0; limit = 16'h0000;
        start1 = 0; stop1 = 0; clear1 = 0; limit1 = 16'h0000;
        repeat (2) @(negedge CLK);
        chk("rst_count", A_count, 0);
        chk("rst_state", state, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_en", digit_en, 0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        // free run, first increment latency and first decade carry
        pulse_start();
        chk("t1_state", state, 2'b01);
        chk("t1_running", running, 1);
        repeat (2) @(negedge CLK);
        chk("t1_pre_inc", A_count, 16'h0000);
        @(negedge CLK);
        chk("t1_en_first", digit_en, 4'b0001);
        @(negedge CLK);
        chk("t1_first_inc", A_count, 16'h0001);
        repeat (35) @(negedge CLK);
        chk("t1_at9", A_count, 16'h0009);
        chk("t1_en_carry", digit_en, 4'b0011);
        @(negedge CLK);
        chk("t1_at10", A_count, 16'h0010);
        do_clear();
        chk("t1_clr_count", A_count, 0);
        chk("t1_clr_state", state, 0);

        // terminal value, hold in DONE, restart
        limit = 16'h0012;
        pulse_start();
        repeat (47) @(negedge CLK);
        chk("t2_pre_term", A_count, 16'h0011);
        chk("t2_pre_done", done, 0);
        @(negedge CLK);
        chk("t2_term_count", A_count, 16'h0012);
        chk("t2_done_hi", done, 1);
        chk("t2_state_done", state, 2'b11);
        chk("t2_running_lo", running, 0);
        @(negedge CLK);
        chk("t2_done_pulse", done, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (A_count !== 16'h0012 || state !== 2'b11 || done !== 1'b0) bad++;
        end
        chk("t2_hold", bad, 0);
        pulse_start();
        chk("t2_restart_count", A_count, 0);
        chk("t2_restart_state", state, 2'b01);
        repeat (3) @(negedge CLK);
        chk("t2_restart_pre", A_count, 0);
        @(negedge CLK);
        chk("t2_restart_inc", A_count, 16'h0001);
        do_clear();

        // pause with prescaler retained
        limit = 16'h0000;
        pulse_start();
        repeat (20) @(negedge CLK);
        chk("t3_at5", A_count, 16'h0005);
        @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        chk("t3_pause_state", state, 2'b10);
        chk("t3_pause_running", running, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (A_count !== 16'h0005 || state !== 2'b10) bad++;
        end
        chk("t3_pause_hold", bad, 0);
        start = 1'b1; stop = 1'b1;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
        chk("t3_startstop_state", state, 2'b10);
        pulse_start();
        chk("t3_resume_state", state, 2'b01);
        chk("t3_resume_count", A_count, 16'h0005);
        @(negedge CLK);
        chk("t3_resume_mid", A_count, 16'h0005);
        @(negedge CLK);
        chk("t3_resume_inc", A_count, 16'h0006);

        // stop coincident with tick, then clear+start in RUN
        repeat (3) @(negedge CLK);
        chk("t5_en_pre", digit_en, 4'b0001);
        stop = 1'b1;
        #1;
        chk("t5_en_stop", digit_en, 4'b0000);
        @(negedge CLK);
        stop = 1'b0;
        chk("t5_stop_state", state, 2'b10);
        chk("t5_stop_count", A_count, 16'h0006);
        pulse_start();
        chk("t5_resume_count", A_count, 16'h0006);
        chk("t5_resume_en", digit_en, 4'b0001);
        @(negedge CLK);
        chk("t5_resume_inc", A_count, 16'h0007);
        clear = 1'b1; start = 1'b1;
        #1;
        chk("t5_clr_en", digit_en, 4'b0000);
        @(negedge CLK);
        clear = 1'b0; start = 1'b0;
        chk("t5_clr_count", A_count, 0);
        chk("t5_clr_state", state, 0);

        // asynchronous reset mid-count
        pulse_start();
        repeat (148) @(negedge CLK);
        chk("t6_at37", A_count, 16'h0037);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_count", A_count, 0);
        chk("t6_async_state", state, 0);
        chk("t6_async_running", running, 0);
        repeat (3) @(negedge CLK);
        chk("t6_held_count", A_count, 0);
        reset = 1'b1;
        repeat (5) @(negedge CLK);
        chk("t6_idle_count", A_count, 0);
        chk("t6_idle_state", state, 0);
        pulse_start();
        chk("t6_start_state", state, 2'b01);
        do_clear();

        // PRESCALE=1 full-scale wrap
        start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        chk("t4_start_count", A_count1, 0);
        ndone = 0;
        for (int i = 0; i < 9998; i++) begin
            @(negedge CLK);
            if (done1) ndone++;
        end
        chk("t4_at9998", A_count1, 16'h9998);
        chk("t4_en_9998", digit_en1, 4'b0001);
        @(negedge CLK);
        if (done1) ndone++;
        chk("t4_at9999", A_count1, 16'h9999);
        chk("t4_en_wrap", digit_en1, 4'b1111);
        @(negedge CLK);
        if (done1) ndone++;
        chk("t4_wrap_count", A_count1, 16'h0000);
        chk("t4_wrap_state", state1, 2'b01);
        repeat (3) @(negedge CLK);
        chk("t4_after_wrap", A_count1, 16'h0003);
        chk("t4_no_done", ndone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Controller/sequencer for a cascaded multi-digit BCD counter chain. It owns the run/pause/clear state machine, derives count ticks from CLK through a prescaler, generates per-digit increment enables (decade carry chain), and stops at a programmable BCD terminal value. It holds the digit registers and is the block that front-panel start/stop/clear logic talks to.

Parameters:
DIGITS, 4, number of BCD digits in the chain (1..8)
PRESCALE, 4, CLK cycles per count tick while running (>=1)

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request: start/resume
stop  input  1  single-cycle request: pause
clear  input  1  single-cycle request: zero count, go idle
limit  input  4*DIGITS  BCD terminal value; digit 0 in [3:0]
A_count  output  4*DIGITS  current BCD count, registered
digit_en  output  DIGITS  combinational: digits incrementing at next edge
running  output  1  high in RUN
done  output  1  one-cycle pulse, terminal value reached
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- reset low (async, any time incl. mid-count): A_count=0, prescaler=0, state=IDLE, done=0, running=0; held while low.
- Request priority per edge: clear > stop > start.
- clear, any state: A_count=0, prescaler=0, -> IDLE; digit_en forced 0 that cycle.
- IDLE: start -> RUN, prescaler=0. stop ignored.
- RUN: stop -> PAUSE (start ignored if simultaneous). start alone ignored.
- PAUSE: start alone -> RUN, prescaler and A_count retained (resume mid-period). stop ignored; start+stop -> stay PAUSE.
- DONE: A_count holds limit. start -> A_count=0, prescaler=0, -> RUN. stop ignored.
- Prescaler: advances only in RUN; tick = RUN & prescaler==PRESCALE-1 & !stop & !clear; prescaler wraps to 0 on tick; held in PAUSE. PRESCALE=1 -> tick every RUN cycle.
- Latency: start at edge n (from IDLE) -> first increment at edge n+PRESCALE.
- Carry chain: digit_en[0]=tick; digit_en[k]=tick & digits 0..k-1 all ==9. Enabled digit at 9 -> 0, else +1. Digits never hold non-BCD values.
- Full-scale wrap: all 9s -> all 0s, digit_en all ones that cycle, keeps running, no done.
- Terminal: if tick and next A_count == limit -> state DONE at same edge; done high exactly the cycle A_count first equals limit.
- limit==0 or any limit digit >9: free-run, never DONE.
- running = (state==RUN), registered with state.
- limit may change at any time; compared only at tick.

Test Plan:
(DIGITS=4, PRESCALE=4 unless noted)
- Reset, limit=0000, start pulse -> A_count=0001 4 cycles after start edge; 0009->0010 at tick 10 (40 cycles) with digit_en=0011 that cycle; running=1.
- limit=0012, start -> A_count=0012 at 48 cycles, done high 1 cycle, state=11, A_count holds 0012 for 20 cycles; start -> 0000, state=01, 0001 four cycles later.
- stop one cycle after A_count becomes 0005 -> state=10, A_count 0005 unchanged 20 cycles; start -> 0006 after remaining 2 prescale cycles (prescaler retained).
- PRESCALE=1, limit=0000, run 10000 cycles -> 9999 then 0000, digit_en=1111 on that cycle, done never asserts.
- stop coincident with tick -> no increment, digit_en=0000, PAUSE; clear+start same cycle in RUN -> A_count=0000, IDLE.
- reset driven low between edges mid-RUN at A_count=0037 -> A_count=0000, state=00 immediately, no edge needed; stays until reset high and start.
